// File: rtl/div_seq_param.sv
// Sequential restoring divider: one quotient bit per clock, with a sign fix-up edge and divide-by-zero/overflow flags.
// Define DIV_SIGNED_EN to honour sgn (two's-complement truncating division); otherwise operands are always unsigned.
module div_seq_param #(
   parameter int unsigned DVD_W = 32,
   parameter int unsigned DVS_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             sgn,
   input  logic [DVD_W-1:0] a,
   input  logic [DVS_W-1:0] b,
   output logic [DVD_W-1:0] q,
   output logic [DVS_W-1:0] r,
   output logic             busy,
   output logic             ready,
   output logic             dbz,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(DVD_W);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [DVD_W-1:0] qw, qw_nxt, q_nxt;
   logic [DVS_W-1:0] rem, rem_nxt, dvs, dvs_nxt, r_nxt;
   logic             neg_q, neg_q_nxt, neg_r, neg_r_nxt, ovf_p, ovf_p_nxt;
   logic             dbz_nxt, ovf_nxt;
   logic             sgn_eff;
   logic [DVD_W-1:0] a_mag;
   logic [DVS_W-1:0] b_mag;
   logic [DVS_W:0]   shifted, trial;

`ifdef DIV_SIGNED_EN
   assign sgn_eff = sgn;
`else
   assign sgn_eff = sgn & 1'b0;
`endif

   // Operand magnitudes and the restoring trial subtraction
   always_comb begin
      a_mag   = (sgn_eff && a[DVD_W-1]) ? -a : a;
      b_mag   = (sgn_eff && b[DVS_W-1]) ? -b : b;
      shifted = {rem, qw[DVD_W-1]};
      trial   = shifted - {1'b0, dvs};
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      qw_nxt    = qw;
      rem_nxt   = rem;
      dvs_nxt   = dvs;
      neg_q_nxt = neg_q;
      neg_r_nxt = neg_r;
      ovf_p_nxt = ovf_p;
      q_nxt     = q;
      r_nxt     = r;
      dbz_nxt   = dbz;
      ovf_nxt   = ovf;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               dbz_nxt = 1'b0;
               ovf_nxt = 1'b0;
               if (b == '0) begin
                  state_nxt = DONE;
                  dbz_nxt   = 1'b1;
                  q_nxt     = '1;
                  r_nxt     = a[DVS_W-1:0];
               end else begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
                  qw_nxt    = a_mag;
                  rem_nxt   = '0;
                  dvs_nxt   = b_mag;
                  neg_q_nxt = sgn_eff & (a[DVD_W-1] ^ b[DVS_W-1]);
                  neg_r_nxt = sgn_eff & a[DVD_W-1];
                  ovf_p_nxt = sgn_eff && (a == {1'b1, {(DVD_W-1){1'b0}}}) && (b == '1);
               end
            end
         end
         RUN: begin
            rem_nxt = trial[DVS_W] ? shifted[DVS_W-1:0] : trial[DVS_W-1:0];
            qw_nxt  = {qw[DVD_W-2:0], ~trial[DVS_W]};
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DVD_W-1)) state_nxt = FIX;
         end
         FIX: begin
            // Overflow needs no special case: the magnitude quotient already wraps to the most negative value
            q_nxt     = neg_q ? -qw : qw;
            r_nxt     = neg_r ? -rem : rem;
            ovf_nxt   = ovf_p;
            state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         cnt   <= '0;
         qw    <= '0;
         rem   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         ovf_p <= 1'b0;
         q     <= '0;
         r     <= '0;
         dbz   <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         ready <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         qw    <= qw_nxt;
         rem   <= rem_nxt;
         dvs   <= dvs_nxt;
         neg_q <= neg_q_nxt;
         neg_r <= neg_r_nxt;
         ovf_p <= ovf_p_nxt;
         q     <= q_nxt;
         r     <= r_nxt;
         dbz   <= dbz_nxt;
         ovf   <= ovf_nxt;
         busy  <= (state_nxt == RUN) || (state_nxt == FIX);
         ready <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param: expectations are pushed at launch and popped when ready rises.
module tb_div_seq_param;
   localparam int unsigned DVD_W = 32;
   localparam int unsigned DVS_W = 16;

   typedef struct packed {
      logic [DVD_W-1:0] q;
      logic [DVS_W-1:0] r;
      logic             dbz;
      logic             ovf;
   } res_t;

   logic             clk = 1'b0;
   logic             clr, start, sgn;
   logic [DVD_W-1:0] a, q;
   logic [DVS_W-1:0] b, r;
   logic             busy, ready, dbz, ovf;

   res_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   div_seq_param #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
      .clk(clk), .clr(clr), .start(start), .sgn(sgn), .a(a), .b(b),
      .q(q), .r(r), .busy(busy), .ready(ready), .dbz(dbz), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference: native SV arithmetic, signed path only when the signed build honours sgn
   function automatic res_t model(input logic [DVD_W-1:0] ma, input logic [DVS_W-1:0] mb, input logic ms);
      res_t   e;
      longint sa, sd;
      e = '0;
      if (mb == '0) begin
         e.q = '1; e.r = ma[DVS_W-1:0]; e.dbz = 1'b1;
      end else if (ms) begin
         sa = longint'($signed(ma));
         sd = longint'($signed(mb));
         if (ma == 32'h8000_0000 && mb == 16'hFFFF) begin
            e.q = 32'h8000_0000; e.r = '0; e.ovf = 1'b1;
         end else begin
            e.q = 32'(sa / sd); e.r = 16'(sa % sd);
         end
      end else begin
         e.q = ma / 32'(mb);
         e.r = 16'(ma % 32'(mb));
      end
      return e;
   endfunction

   function automatic res_t got();
      return {q, r, dbz, ovf};
   endfunction

   // Drive one accepting edge, then scramble operands to prove they were latched
   task automatic launch(input logic [DVD_W-1:0] la, input logic [DVS_W-1:0] lb, input logic ls);
      logic se;
      se = 1'b0;
`ifdef DIV_SIGNED_EN
      se = ls;
`endif
      a = la; b = lb; sgn = ls; start = 1'b1;
      sb.push_back(model(la, lb, se));
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = 16'($urandom); sgn = 1'($urandom);
   endtask

   task automatic wait_done(output int edges, output int bcnt);
      edges = 0;
      bcnt  = int'(busy);
      while (!ready && edges < 100) begin
         @(posedge clk); #1;
         edges++;
         if (busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      clr = 1'b1; start = 1'b0; sgn = 1'b0; a = '1; b = '1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, ready, dbz, ovf, q, r} !== '0) begin
         n_fail++;
         $display("FAIL reset: busy=%b ready=%b dbz=%b ovf=%b q=%h r=%h, required all zero", busy, ready, dbz, ovf, q, r);
      end
      clr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned();
      int e, bc; res_t x;
      launch(32'd100, 16'd7, 1'b0);
      wait_done(e, bc);
      x = sb.pop_front();
      n_checks++;
      if (e !== 33) begin n_fail++; $display("FAIL unsigned latency: got %0d edges, required 33", e); end
      n_checks++;
      if (bc !== 33) begin n_fail++; $display("FAIL unsigned busy cycles: got %0d, required 33", bc); end
      n_checks++;
      if (got() !== x) begin n_fail++; $display("FAIL unsigned 100/7: got %h, required %h", got(), x); end
   endtask

   task automatic test_dbz();
      int e, bc; res_t x;
      launch(32'd55, 16'd0, 1'b0);
      wait_done(e, bc);
      x = sb.pop_front();
      n_checks++;
      if (e !== 0 || bc !== 0) begin n_fail++; $display("FAIL dbz timing: extra edges %0d busy %0d, required 0 and 0", e, bc); end
      n_checks++;
      if (got() !== x) begin n_fail++; $display("FAIL dbz result: got %h, required %h", got(), x); end
   endtask

   task automatic test_back_to_back();
      int e, bc; res_t x;
      launch(32'd9, 16'd4, 1'b0);
      n_checks++;
      if (ready !== 1'b0 || dbz !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL restart flags: ready=%b dbz=%b busy=%b, required 0 0 1", ready, dbz, busy);
      end
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (q !== '1 || r !== 16'h0037) begin n_fail++; $display("FAIL q/r hold mid-run: q=%h r=%h, required ffffffff 0037", q, r); end
      wait_done(e, bc);
      x = sb.pop_front();
      n_checks++;
      if (e + 5 !== 33 || got() !== x) begin n_fail++; $display("FAIL back-to-back 9/4: edges %0d got %h, required 33 %h", e + 5, got(), x); end
   endtask

   task automatic test_ignore_start();
      int e; res_t x;
      launch(32'd1000, 16'd33, 1'b0);
      e = 0;
      while (!ready && e < 100) begin
         if (e == 4 || e == 19) begin start = 1'b1; a = 32'd77; b = 16'd3; end
         @(posedge clk); #1;
         start = 1'b0;
         e++;
      end
      x = sb.pop_front();
      n_checks++;
      if (e !== 33 || got() !== x) begin n_fail++; $display("FAIL start during run: edges %0d got %h, required 33 %h", e, got(), x); end
   endtask

   task automatic test_signed();
      int e, bc; res_t x;
      logic [DVD_W-1:0] av [4];
      logic [DVS_W-1:0] bv [4];
      logic             sv [4];
      av = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'h8000_0000, 32'h0000_0064};
      bv = '{16'd7,         16'd7,         16'hFFFF,      16'hFFF9};
      sv = '{1'b1,          1'b0,          1'b1,          1'b1};
      for (int i = 0; i < 4; i++) begin
         launch(av[i], bv[i], sv[i]);
         wait_done(e, bc);
         x = sb.pop_front();
         n_checks++;
         if (e !== 33 || got() !== x) begin
            n_fail++; $display("FAIL signed case %0d: edges %0d got %h, required 33 %h", i, e, got(), x);
         end
      end
   endtask

   task automatic test_clr_mid_run();
      int e, bc; res_t x;
      launch(32'hDEAD_BEEF, 16'd13, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      void'(sb.pop_front());
      n_checks++;
      if ({busy, ready, dbz, ovf, q, r} !== '0) begin
         n_fail++; $display("FAIL clr mid-run: busy=%b ready=%b q=%h r=%h, required all zero", busy, ready, q, r);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL idle after clr: busy=%b ready=%b, required 0 0", busy, ready); end
      launch(32'hFFFF_FFFF, 16'hFFFF, 1'b0);
      wait_done(e, bc);
      x = sb.pop_front();
      n_checks++;
      if (e !== 33 || got() !== x) begin n_fail++; $display("FAIL after clr ffffffff/ffff: edges %0d got %h, required 33 %h", e, got(), x); end
   endtask

   task automatic test_random();
      int e, bc; res_t x;
      logic [DVS_W-1:0] rb;
      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = 16'($urandom_range(1, 15));
            default: rb = 16'($urandom);
         endcase
         launch($urandom, rb, 1'($urandom));
         wait_done(e, bc);
         x = sb.pop_front();
         n_checks++;
         if (e !== ((rb == '0) ? 0 : 33) || got() !== x) begin
            n_fail++; $display("FAIL random op %0d b=%h: edges %0d got %h, required %h", i, rb, e, got(), x);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_dbz();
      test_back_to_back();
      test_ignore_start();
      test_signed();
      test_clr_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
